// File: rtl/dot_box_pkg.sv
// Shared constants and types for the dot-product box front end.
package dot_box_pkg;

  localparam int N_ELEM = 8;
  localparam int DW     = 16;
  localparam int RW     = 32;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN
  } state_e;

  typedef logic signed [N_ELEM-1:0][DW-1:0] dot_vec_t;

endpackage

// File: rtl/dot_pingpong_buf.sv
// Two-bank (x, y) vector store: fills one bank beat by beat while the other
// bank is held steady for the dot-product engine.
module dot_pingpong_buf #(
  parameter int N_ELEM = 8,
  parameter int DW     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [DW-1:0]   s_x,
  input  logic signed [DW-1:0]   s_y,
  input  logic                   rd_free,
  output logic                   rd_full,
  output logic [N_ELEM*DW-1:0]   dot_x,
  output logic [N_ELEM*DW-1:0]   dot_y
);

  localparam int PW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_ELEM - 1);

  logic [N_ELEM-1:0][DW-1:0] bank_x_q [2];
  logic [N_ELEM-1:0][DW-1:0] bank_x_d [2];
  logic [N_ELEM-1:0][DW-1:0] bank_y_q [2];
  logic [N_ELEM-1:0][DW-1:0] bank_y_d [2];
  logic [1:0]                full_q, full_d;
  logic                      wr_bank_q, wr_bank_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic                      rd_bank_q, rd_bank_d;
  logic                      wr_en;

  assign s_ready = !full_q[wr_bank_q];
  assign wr_en   = s_valid && s_ready;

  // A write can only target a non-full bank and a free only a full one, so
  // both may land in the same cycle without touching the same flag.
  always_comb begin
    bank_x_d  = bank_x_q;
    bank_y_d  = bank_y_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_ptr_d  = wr_ptr_q;
    rd_bank_d = rd_bank_q;
    if (wr_en) begin
      bank_x_d[wr_bank_q][wr_ptr_q] = s_x;
      bank_y_d[wr_bank_q][wr_ptr_q] = s_y;
      if (wr_ptr_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_ptr_d          = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
    if (rd_free) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_x_q  <= '{default: '0};
      bank_y_q  <= '{default: '0};
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      bank_x_q  <= bank_x_d;
      bank_y_q  <= bank_y_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign rd_full = full_q[rd_bank_q];
  assign dot_x   = bank_x_q[rd_bank_q];
  assign dot_y   = bank_y_q[rd_bank_q];

endmodule

// File: rtl/dot_vec_feeder.sv
// Front end for dot_box_top: assembles beats into vectors, sequences the
// engine start/done handshake and holds the result until it is consumed.
module dot_vec_feeder
  import dot_box_pkg::*;
#(
  parameter int N_ELEM  = dot_box_pkg::N_ELEM,
  parameter int DW      = dot_box_pkg::DW,
  parameter int RW      = dot_box_pkg::RW,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [DW-1:0]   s_x,
  input  logic signed [DW-1:0]   s_y,
  output logic [N_ELEM*DW-1:0]   dot_x,
  output logic [N_ELEM*DW-1:0]   dot_y,
  output logic                   dot_start,
  input  logic                   dot_xfc,
  input  logic signed [RW-1:0]   dot_dat,
  input  logic signed [DW-1:0]   dot_dat16,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic signed [RW-1:0]   r_dat,
  output logic signed [DW-1:0]   r_dat16,
  output logic                   busy,
  output logic                   err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // cnt_q holds (cycles since dot_start) - 1, so giving up at the end of
  // this value raises err exactly TIMEOUT cycles after dot_start.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  r_valid_q, r_valid_d;
  logic signed [RW-1:0]  r_dat_q, r_dat_d;
  logic signed [DW-1:0]  r_dat16_q, r_dat16_d;
  logic                  err_q, err_d;
  logic                  dot_start_q, dot_start_d;
  logic                  busy_q, busy_d;
  logic                  buf_free;
  logic                  buf_full;

  dot_pingpong_buf #(
    .N_ELEM (N_ELEM),
    .DW     (DW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_x     (s_x),
    .s_y     (s_y),
    .rd_free (buf_free),
    .rd_full (buf_full),
    .dot_x   (dot_x),
    .dot_y   (dot_y)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_valid_d = r_valid_q && !r_ready;
    r_dat_d   = r_dat_q;
    r_dat16_d = r_dat16_q;
    err_d     = err_q;
    buf_free  = 1'b0;
    case (state_q)
      IDLE: begin
        // A result being consumed this cycle no longer blocks the next start.
        if (buf_full && !r_valid_d) state_d = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (dot_xfc) begin
          r_dat_d   = dot_dat;
          r_dat16_d = dot_dat16;
          r_valid_d = 1'b1;
          buf_free  = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d    = 1'b1;
          buf_free = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    dot_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_valid_q   <= 1'b0;
      r_dat_q     <= '0;
      r_dat16_q   <= '0;
      err_q       <= 1'b0;
      dot_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_valid_q   <= r_valid_d;
      r_dat_q     <= r_dat_d;
      r_dat16_q   <= r_dat16_d;
      err_q       <= err_d;
      dot_start_q <= dot_start_d;
      busy_q      <= busy_d;
    end
  end

  assign dot_start = dot_start_q;
  assign busy      = busy_q;
  assign r_valid   = r_valid_q;
  assign r_dat     = r_dat_q;
  assign r_dat16   = r_dat16_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dot_vec_feeder.sv
// Directed bench for dot_vec_feeder with a behavioural stand-in for the
// dot-product engine (done 9 cycles after start, or never when disabled).
module tb_dot_vec_feeder;
  import dot_box_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DW-1:0]     s_x, s_y;
  logic [N_ELEM*DW-1:0]     dot_x, dot_y;
  logic                     dot_start;
  logic                     dot_xfc;
  logic signed [RW-1:0]     dot_dat;
  logic signed [DW-1:0]     dot_dat16;
  logic                     r_valid;
  logic                     r_ready;
  logic signed [RW-1:0]     r_dat;
  logic signed [DW-1:0]     r_dat16;
  logic                     busy;
  logic                     err;

  dot_vec_feeder #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_x       (s_x),
    .s_y       (s_y),
    .dot_x     (dot_x),
    .dot_y     (dot_y),
    .dot_start (dot_start),
    .dot_xfc   (dot_xfc),
    .dot_dat   (dot_dat),
    .dot_dat16 (dot_dat16),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_dat     (r_dat),
    .r_dat16   (r_dat16),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int start_cyc [$];
  logic [N_ELEM*DW-1:0] start_x [$];
  logic [N_ELEM*DW-1:0] start_y [$];
  logic [RW-1:0] res_dat [$];
  logic [DW-1:0] res16 [$];
  int rv_cyc [$];
  int rv_high = 0;
  int err_cyc = -1;
  int last_acc = 0;
  logic rv_prev = 1'b0;
  logic err_prev = 1'b0;
  logic engine_on = 1'b1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic dot_vec_t pack(input logic signed [15:0] v [8]);
    dot_vec_t p;
    for (int i = 0; i < 8; i++) p[i] = v[i];
    return p;
  endfunction

  // Engine stand-in: 64-bit accumulate, saturate to 32 bits and (>>>16) to 16 bits.
  function automatic void eng(input logic [127:0] vx, input logic [127:0] vy,
                              output logic [31:0] d, output logic [15:0] d16);
    longint acc, sh;
    acc = 0;
    for (int i = 0; i < 8; i++)
      acc += longint'($signed(vx[i*16 +: 16])) * longint'($signed(vy[i*16 +: 16]));
    if (acc > 64'sd2147483647) d = 32'h7FFF_FFFF;
    else if (acc < -64'sd2147483648) d = 32'h8000_0000;
    else d = acc[31:0];
    sh = acc >>> 16;
    if (sh > 64'sd32767) d16 = 16'h7FFF;
    else if (sh < -64'sd32768) d16 = 16'h8000;
    else d16 = sh[15:0];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (dot_start) begin
      n_start++;
      start_cyc.push_back(cyc);
      start_x.push_back(dot_x);
      start_y.push_back(dot_y);
    end
    if (r_valid) rv_high++;
    if (r_valid && !rv_prev) rv_cyc.push_back(cyc);
    rv_prev = r_valid;
    if (r_valid && r_ready) begin
      res_dat.push_back(r_dat);
      res16.push_back(r_dat16);
    end
    if (err && !err_prev) err_cyc = cyc;
    err_prev = err;
  end

  initial begin
    logic [31:0] d;
    logic [15:0] d16;
    logic aborted;
    dot_xfc = 1'b0;
    dot_dat = '0;
    dot_dat16 = '0;
    forever begin
      @(negedge clk);
      if (dot_start && engine_on && !reset) begin
        eng(dot_x, dot_y, d, d16);
        aborted = 1'b0;
        for (int k = 0; k < 9; k++) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
        end
        if (!aborted) begin
          dot_xfc = 1'b1;
          dot_dat = d;
          dot_dat16 = d16;
          @(negedge clk);
          dot_xfc = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y, output int st);
    logic ok;
    s_valid = 1'b1;
    s_x = x;
    s_y = y;
    st = 0;
    ok = 1'b0;
    while (!ok && st < 100) begin
      @(negedge clk);
      ok = s_ready;
      if (ok) last_acc = cyc;
      @(posedge clk);
      #1;
      if (!ok) st++;
    end
    s_valid = 1'b0;
  endtask

  task automatic send_vec(input logic signed [15:0] xs [8], input logic signed [15:0] ys [8],
                          output int st_total, output int st_first);
    int st;
    st_total = 0;
    st_first = 0;
    for (int i = 0; i < 8; i++) begin
      send(xs[i], ys[i], st);
      if (i == 0) st_first = st;
      st_total += st;
    end
  endtask

  task automatic wait_starts(input int n, input int lim);
    int k = 0;
    while (n_start < n && k < lim) begin
      tick(1);
      k++;
    end
  endtask

  task automatic wait_res(input int n, input int lim);
    int k = 0;
    while (res_dat.size() < n && k < lim) begin
      tick(1);
      k++;
    end
  endtask

  initial begin
    logic signed [15:0] xs [8];
    logic signed [15:0] ys [8];
    int st, st_first, st_sum, bs, br, rvb;

    reset = 1'b1;
    s_valid = 1'b0;
    s_x = '0;
    s_y = '0;
    r_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_dat", r_dat, 0);
    check("rst_r_dat16", r_dat16, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_dot_start", dot_start, 0);
    check("rst_dot_x", dot_x, 0);
    check("rst_dot_y", dot_y, 0);
    @(posedge clk);
    #1;

    // Single vector: x = 1..8, y = 1
    for (int i = 0; i < 8; i++) begin xs[i] = 16'(i + 1); ys[i] = 16'sd1; end
    send_vec(xs, ys, st, st_first);
    check("t1_stall", st, 0);
    wait_starts(1, 20);
    check("t1_n_start", n_start, 1);
    if (start_cyc.size() > 0) begin
      check("t1_start_lat", start_cyc[0] - last_acc, 2);
      check("t1_dot_x", start_x[0], pack(xs));
      check("t1_dot_y", start_y[0], pack(ys));
    end
    wait_res(1, 40);
    check("t1_n_res", res_dat.size(), 1);
    if (res_dat.size() > 0) begin
      check("t1_r_dat", res_dat[0], 36);
      check("t1_r_dat16", res16[0], 0);
    end
    if (rv_cyc.size() > 0 && start_cyc.size() > 0)
      check("t1_rv_lat", rv_cyc[0] - start_cyc[0], 10);
    check("t1_err", err, 0);

    // Back-to-back: 16 beats, no stall, 11-cycle start spacing
    bs = n_start;
    br = res_dat.size();
    for (int i = 0; i < 8; i++) begin xs[i] = 16'(i + 1); ys[i] = 16'sd2; end
    send_vec(xs, ys, st, st_first);
    st_sum = st;
    for (int i = 0; i < 8; i++) begin xs[i] = 16'sh0100; ys[i] = 16'sh0100; end
    send_vec(xs, ys, st, st_first);
    st_sum += st;
    check("t2_no_stall", st_sum, 0);
    wait_res(br + 2, 60);
    check("t2_n_res", res_dat.size(), br + 2);
    if (res_dat.size() >= br + 2) begin
      check("t2_r_dat_a", res_dat[br], 72);
      check("t2_r_dat16_a", res16[br], 0);
      check("t2_r_dat_b", res_dat[br + 1], 524288);
      check("t2_r_dat16_b", res16[br + 1], 8);
    end
    if (start_cyc.size() >= bs + 2)
      check("t2_spacing", start_cyc[bs + 1] - start_cyc[bs], 11);

    // Back-pressure: r_ready low, three vectors offered
    bs = n_start;
    br = res_dat.size();
    r_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin xs[i] = 16'(i + 1); ys[i] = 16'sd3; end
    send_vec(xs, ys, st, st_first);
    st_sum = st;
    for (int i = 0; i < 8; i++) begin xs[i] = 16'sh0100; ys[i] = 16'sh0100; end
    send_vec(xs, ys, st, st_first);
    st_sum += st;
    check("t3_16_no_stall", st_sum, 0);
    for (int i = 0; i < 8; i++) begin xs[i] = 16'(i); ys[i] = 16'(i); end
    send_vec(xs, ys, st, st_first);
    check("t3_beat17_stalls", (st_first > 0), 1);
    tick(30);
    check("t3_one_start", n_start, bs + 1);
    @(negedge clk);
    check("t3_r_valid_held", r_valid, 1);
    check("t3_r_dat_held", r_dat, 108);
    check("t3_no_res_yet", res_dat.size(), br);
    @(posedge clk);
    #1;
    r_ready = 1'b1;
    wait_res(br + 3, 80);
    check("t3_n_res", res_dat.size(), br + 3);
    if (res_dat.size() >= br + 3) begin
      check("t3_res0", res_dat[br], 108);
      check("t3_res1", res_dat[br + 1], 524288);
      check("t3_res1_16", res16[br + 1], 8);
      check("t3_res2", res_dat[br + 2], 140);
    end
    check("t3_n_start", n_start, bs + 3);

    // Saturated result passes through unmodified
    br = res_dat.size();
    for (int i = 0; i < 8; i++) begin xs[i] = 16'sh8000; ys[i] = 16'sh8000; end
    send_vec(xs, ys, st, st_first);
    wait_res(br + 1, 40);
    check("t4_n_res", res_dat.size(), br + 1);
    if (res_dat.size() > br) begin
      check("t4_r_dat_sat", res_dat[br], 32'h7FFF_FFFF);
      check("t4_r_dat16_sat", res16[br], 16'h7FFF);
    end

    // Timeout: engine never answers
    engine_on = 1'b0;
    bs = n_start;
    br = res_dat.size();
    rvb = rv_high;
    for (int i = 0; i < 8; i++) begin xs[i] = 16'(i + 1); ys[i] = 16'sd1; end
    send_vec(xs, ys, st, st_first);
    wait_starts(bs + 1, 20);
    for (int k = 0; k < 40 && err_cyc < 0; k++) tick(1);
    check("t5_err", err, 1);
    if (start_cyc.size() > bs)
      check("t5_err_lat", err_cyc - start_cyc[bs], 16);
    check("t5_no_r_valid", rv_high, rvb);
    check("t5_busy_clear", busy, 0);
    engine_on = 1'b1;
    for (int i = 0; i < 8; i++) begin xs[i] = 16'sd2; ys[i] = 16'(i + 1); end
    send_vec(xs, ys, st, st_first);
    wait_res(br + 1, 40);
    check("t5_next_n_res", res_dat.size(), br + 1);
    if (res_dat.size() > br) check("t5_next_r_dat", res_dat[br], 72);
    check("t5_err_sticky", err, 1);

    // Reset mid-load
    for (int i = 0; i < 5; i++) send(16'(i + 100), 16'sd1, st);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    check("t6a_s_ready", s_ready, 1);
    check("t6a_err", err, 0);
    check("t6a_r_dat", r_dat, 0);
    check("t6a_dot_x", dot_x, 0);
    check("t6a_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset mid-RUN
    bs = n_start;
    br = res_dat.size();
    for (int i = 0; i < 8; i++) begin xs[i] = 16'(i + 1); ys[i] = 16'sd1; end
    send_vec(xs, ys, st, st_first);
    wait_starts(bs + 1, 20);
    tick(3);
    check("t6b_busy_before", busy, 1);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    check("t6b_busy", busy, 0);
    check("t6b_dot_x", dot_x, 0);
    check("t6b_dot_y", dot_y, 0);
    check("t6b_r_valid", r_valid, 0);
    check("t6b_dot_start", dot_start, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(15);
    check("t6b_no_res", res_dat.size(), br);
    for (int i = 0; i < 8; i++) begin xs[i] = 16'(i + 1); ys[i] = 16'(i + 1); end
    send_vec(xs, ys, st, st_first);
    wait_res(br + 1, 40);
    check("t6c_n_res", res_dat.size(), br + 1);
    if (res_dat.size() > br) begin
      check("t6c_r_dat", res_dat[br], 204);
      check("t6c_r_dat16", res16[br], 0);
    end
    check("t6c_n_start", n_start, bs + 2);
    check("t6c_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
